// File: rtl/cpu_launch_pkg.sv
// Shared types and default sizing for the CPU launch controller.
package cpu_launch_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_RELEASE = 3'd2,
      S_FINISH  = 3'd3,
      S_ERR     = 3'd4
   } launch_state_t;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_RUN_W   = 8;
   localparam int DEF_TIMEOUT = 1_000_000;

endpackage

// File: rtl/launch_watchdog.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// (registered) once the count reaches TIMEOUT-1.
module launch_watchdog
   import cpu_launch_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LIM    = W'(TIMEOUT - 1);
   localparam logic [W-1:0] PRE_LIM = W'(TIMEOUT - 2);

   logic [W-1:0] r_cnt;
   logic         r_expired;

   // Count while enabled; expired rises together with the count reaching the limit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (i_clr) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (i_en) begin
         if (r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
         r_expired <= r_expired || (r_cnt == PRE_LIM);
      end else begin
         r_expired <= 1'b0;
      end
   end

   assign o_expired = r_expired;

endmodule

// File: rtl/cpu_launch_ctrl.sv
// Host-side start/done initiator for the CPU core: four-phase handshake,
// repeated runs, per-run cycle capture and a per-phase watchdog.
//
// state     | meaning
// S_IDLE    | waiting for go
// S_START   | start_sig high, waiting for cpu_done=1
// S_RELEASE | start_sig low, waiting for cpu_done=0
// S_FINISH  | one-cycle finish pulse
// S_ERR     | watchdog expired, error held until go/abort
module cpu_launch_ctrl
   import cpu_launch_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int RUN_W   = DEF_RUN_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_go,
   input  logic             i_abort,
   input  logic [RUN_W-1:0] i_n_runs,
   input  logic             i_cpu_done,
   output logic             o_start_sig,
   output logic             o_busy,
   output logic             o_finish,
   output logic             o_error,
   output logic [RUN_W-1:0] o_runs_done,
   output logic [CNT_W-1:0] o_last_cycles
);

   localparam logic [CNT_W-1:0] CYC_MAX = '1;

   launch_state_t    r_state, w_next;
   logic [CNT_W-1:0] r_cyc, r_last;
   logic [RUN_W-1:0] r_runs_tgt, r_runs_done;

   logic w_launch, w_capture, w_rerun, w_wd_clr, w_wd_en, w_expired;

   assign w_wd_en = (r_state == S_START) || (r_state == S_RELEASE);

   launch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_expired)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and datapath strobes; abort overrides everything.
   always_comb begin
      w_next    = r_state;
      w_launch  = 1'b0;
      w_capture = 1'b0;
      w_rerun   = 1'b0;
      w_wd_clr  = 1'b0;
      if (i_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_ERR: begin
               if (i_go) begin
                  w_launch = 1'b1;
                  w_wd_clr = 1'b1;
                  w_next   = S_START;
               end
            end
            S_START: begin
               if (i_cpu_done) begin
                  w_capture = 1'b1;
                  w_wd_clr  = 1'b1;
                  w_next    = S_RELEASE;
               end else if (w_expired) begin
                  w_next = S_ERR;
               end
            end
            S_RELEASE: begin
               if (!i_cpu_done) begin
                  if (r_runs_done == r_runs_tgt) begin
                     w_next = S_FINISH;
                  end else begin
                     w_rerun  = 1'b1;
                     w_wd_clr = 1'b1;
                     w_next   = S_START;
                  end
               end else if (w_expired) begin
                  w_next = S_ERR;
               end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   // Run bookkeeping and saturating cycle counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cyc       <= '0;
         r_last      <= '0;
         r_runs_tgt  <= '0;
         r_runs_done <= '0;
      end else if (w_launch) begin
         r_runs_tgt  <= (i_n_runs == '0) ? RUN_W'(1) : i_n_runs;
         r_runs_done <= '0;
         r_cyc       <= '0;
      end else if (w_rerun) begin
         r_cyc <= '0;
      end else if (r_state == S_START) begin
         if (w_capture) begin
            r_last <= (r_cyc == CYC_MAX) ? r_cyc : r_cyc + 1'b1;
            if (r_runs_done < r_runs_tgt) r_runs_done <= r_runs_done + 1'b1;
         end else if (r_cyc != CYC_MAX) begin
            r_cyc <= r_cyc + 1'b1;
         end
      end
   end

   assign o_start_sig   = (r_state == S_START);
   assign o_busy        = (r_state == S_START) || (r_state == S_RELEASE);
   assign o_finish      = (r_state == S_FINISH);
   assign o_error       = (r_state == S_ERR);
   assign o_runs_done   = r_runs_done;
   assign o_last_cycles = r_last;

endmodule

// File: tb/tb_cpu_launch_ctrl.sv
// Directed bench for cpu_launch_ctrl with a short watchdog.
module tb_cpu_launch_ctrl;

   localparam int CNT_W   = 32;
   localparam int RUN_W   = 8;
   localparam int TIMEOUT = 16;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_go = 1'b0;
   logic             i_abort = 1'b0;
   logic [RUN_W-1:0] i_n_runs = '0;
   logic             i_cpu_done = 1'b0;
   logic             o_start_sig, o_busy, o_finish, o_error;
   logic [RUN_W-1:0] o_runs_done;
   logic [CNT_W-1:0] o_last_cycles;

   int n_cmp = 0;
   int n_fail = 0;
   int fin_cnt = 0;
   int fin0;
   int hi;

   cpu_launch_ctrl #(.CNT_W(CNT_W), .RUN_W(RUN_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_go          (i_go),
      .i_abort       (i_abort),
      .i_n_runs      (i_n_runs),
      .i_cpu_done    (i_cpu_done),
      .o_start_sig   (o_start_sig),
      .o_busy        (o_busy),
      .o_finish      (o_finish),
      .o_error       (o_error),
      .o_runs_done   (o_runs_done),
      .o_last_cycles (o_last_cycles)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; count finish pulses seen there.
   task automatic step();
      @(negedge i_clk);
      if (o_finish) fin_cnt++;
   endtask

   task automatic launch(input int n);
      i_n_runs = RUN_W'(n);
      i_go = 1'b1;
      step();
      i_go = 1'b0;
   endtask

   // Called on the first START cycle; core answers after lat cycles and
   // drops done 3 cycles after start_sig falls.
   task automatic run_cpu(input int lat, input string tag);
      int h;
      h = 0;
      for (int i = 0; i < lat; i++) begin
         if (o_start_sig) h++;
         if (i == lat - 1) i_cpu_done = 1'b1;
         step();
      end
      check({tag, "_last"}, o_last_cycles, 64'(lat));
      for (int j = 0; j < 3; j++) begin
         if (o_start_sig) h++;
         if (j == 2) i_cpu_done = 1'b0;
         else step();
      end
      step();
      check({tag, "_start_hi"}, 64'(h), 64'(lat));
   endtask

   initial begin
      step();
      step();
      check("rst_start", o_start_sig, 0);
      check("rst_busy", o_busy, 0);
      check("rst_finish", o_finish, 0);
      check("rst_error", o_error, 0);
      check("rst_runs", o_runs_done, 0);
      check("rst_last", o_last_cycles, 0);
      i_rst = 1'b0;
      step();

      // single run
      fin0 = fin_cnt;
      launch(1);
      check("s_start", o_start_sig, 1);
      check("s_busy", o_busy, 1);
      check("s_runs0", o_runs_done, 0);
      run_cpu(10, "single");
      check("s_finish", o_finish, 1);
      check("s_runs", o_runs_done, 1);
      check("s_busy_end", o_busy, 0);
      step();
      check("s_finish_off", o_finish, 0);
      check("s_fin_pulses", 64'(fin_cnt - fin0), 1);

      // three runs
      fin0 = fin_cnt;
      launch(3);
      run_cpu(5, "m1");
      check("m1_restart", o_start_sig, 1);
      check("m1_nofin", o_finish, 0);
      check("m1_runs", o_runs_done, 1);
      run_cpu(7, "m2");
      check("m2_restart", o_start_sig, 1);
      check("m2_runs", o_runs_done, 2);
      run_cpu(4, "m3");
      check("m3_finish", o_finish, 1);
      check("m3_runs", o_runs_done, 3);
      step();
      check("m_fin_pulses", 64'(fin_cnt - fin0), 1);

      // n_runs = 0 behaves as one run
      launch(0);
      run_cpu(3, "z");
      check("z_finish", o_finish, 1);
      check("z_runs", o_runs_done, 1);
      step();

      // watchdog in START
      fin0 = fin_cnt;
      launch(2);
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      check("t_err_early", o_error, 0);
      check("t_start_early", o_start_sig, 1);
      step();
      check("t_err", o_error, 1);
      check("t_start", o_start_sig, 0);
      check("t_busy", o_busy, 0);
      step();
      check("t_err_sticky", o_error, 1);
      check("t_nofin", 64'(fin_cnt - fin0), 0);
      launch(1);
      check("t_relaunch_err", o_error, 0);
      check("t_relaunch_start", o_start_sig, 1);
      check("t_relaunch_runs", o_runs_done, 0);
      run_cpu(2, "tr");
      check("tr_finish", o_finish, 1);
      step();

      // done stuck high in RELEASE
      launch(2);
      step();
      step();
      i_cpu_done = 1'b1;
      step();
      check("k_start", o_start_sig, 0);
      check("k_busy", o_busy, 1);
      check("k_last", o_last_cycles, 3);
      hi = 0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         if (o_start_sig) hi++;
      end
      check("k_err_early", o_error, 0);
      step();
      check("k_err", o_error, 1);
      check("k_start_err", o_start_sig, 0);
      i_cpu_done = 1'b0;
      step();
      step();
      check("k_err_hold", o_error, 1);
      check("k_no_restart", 64'(hi) + 64'(o_start_sig), 0);
      check("k_runs", o_runs_done, 1);

      // abort out of ERR
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      check("a_err_clr", o_error, 0);
      check("a_runs_hold", o_runs_done, 1);

      // abort mid-START
      fin0 = fin_cnt;
      launch(1);
      step();
      step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      check("ab_start", o_start_sig, 0);
      check("ab_busy", o_busy, 0);
      check("ab_runs", o_runs_done, 0);
      check("ab_last_hold", o_last_cycles, 3);
      step();
      step();
      check("ab_idle", o_start_sig, 0);

      // go and abort together from IDLE
      i_go = 1'b1;
      i_abort = 1'b1;
      step();
      i_go = 1'b0;
      i_abort = 1'b0;
      check("ga_start", o_start_sig, 0);
      check("ga_busy", o_busy, 0);
      step();
      check("ga_start2", o_start_sig, 0);
      check("ab_nofin", 64'(fin_cnt - fin0), 0);

      // asynchronous reset mid-sequence
      launch(2);
      run_cpu(3, "r1");
      check("r_runs_pre", o_runs_done, 1);
      step();
      #2 i_rst = 1'b1;
      #1;
      check("r_start", o_start_sig, 0);
      check("r_busy", o_busy, 0);
      check("r_runs", o_runs_done, 0);
      check("r_last", o_last_cycles, 0);
      check("r_error", o_error, 0);
      step();
      i_rst = 1'b0;
      step();
      launch(1);
      check("r_go_start", o_start_sig, 1);
      check("r_go_runs", o_runs_done, 0);
      run_cpu(6, "r2");
      check("r2_finish", o_finish, 1);
      check("r2_runs", o_runs_done, 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
